// File: rtl/rename_tag_allocator.sv
// rename_tag_allocator: circular free list of rename tags with refill FSM, dual alloc/release ports.
// Optional RENAME_TAG_CHECK_EN adds an in-use vector and a sticky misuse flag on o_error.
module rename_tag_allocator #(
    parameter int NUM_TAGS = 32,
    localparam int TAG_W = $clog2(NUM_TAGS)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_halt,
    input  logic [1:0]       i_alloc_count,
    output logic [TAG_W-1:0] o_alloc_tag [2],
    output logic             o_alloc_valid [2],
    input  logic             i_free_valid [2],
    input  logic [TAG_W-1:0] i_free_tag [2],
    output logic [1:0]       o_capacity,
    output logic             o_busy,
    output logic             o_error
);
    typedef enum logic {REFILL, RUN} state_t;
    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0] LAST = FULL - (TAG_W+1)'(2);
    localparam logic [TAG_W-1:0] ONE = 1;
    state_t state;
    logic [TAG_W-1:0] mem [NUM_TAGS];
    logic [TAG_W-1:0] head, tail, idx_t;
    logic [TAG_W:0] count, idx, pop_n, push_n;
    logic run, live, over, pop, ok0, ok1;
    assign run = state == RUN;
    assign live = run && !i_flush;
    assign idx_t = idx[TAG_W-1:0];
    assign o_busy = !run;
    assign o_capacity = !run ? 2'd0 : count > 1 ? 2'd2 : count[1:0];
    assign o_alloc_valid[0] = run && count != 0;
    assign o_alloc_valid[1] = run && count > 1;
    assign o_alloc_tag[0] = mem[head];
    assign o_alloc_tag[1] = mem[head + ONE];
    // An over-capacity request is dropped whole rather than partially served.
    assign over = live && !i_halt && i_alloc_count > o_capacity;
    assign pop = live && !i_halt && !over;
    assign pop_n = pop ? (TAG_W+1)'(i_alloc_count) : '0;
    assign push_n = (TAG_W+1)'(ok0) + (TAG_W+1)'(ok1);
`ifdef RENAME_TAG_CHECK_EN
    logic [NUM_TAGS-1:0] in_use;
    logic err;
    assign ok0 = live && i_free_valid[0] && count != FULL && in_use[i_free_tag[0]];
    // Slot 1 sees the list after slot 0, so a duplicate pair frees only once.
    assign ok1 = live && i_free_valid[1] && (count + (TAG_W+1)'(ok0)) != FULL
                 && in_use[i_free_tag[1]] && !(ok0 && i_free_tag[0] == i_free_tag[1]);
    assign o_error = err;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            in_use <= '0;
            err <= 1'b0;
        end else if (i_flush) begin
            in_use <= '0;
        end else begin
            if (pop && i_alloc_count != 2'd0) in_use[mem[head]] <= 1'b1;
            if (pop && i_alloc_count == 2'd2) in_use[mem[head + ONE]] <= 1'b1;
            if (ok0) in_use[i_free_tag[0]] <= 1'b0;
            if (ok1) in_use[i_free_tag[1]] <= 1'b0;
            if (over || (live && ((i_free_valid[0] && !ok0) || (i_free_valid[1] && !ok1)))) err <= 1'b1;
        end
    end
`else
    assign ok0 = live && i_free_valid[0];
    assign ok1 = live && i_free_valid[1];
    assign o_error = 1'b0;
`endif
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= REFILL;
            idx <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (i_flush) begin
            state <= REFILL;
            idx <= '0;
            count <= '0;
        end else if (!run) begin
            idx <= idx + (TAG_W+1)'(2);
            if (idx == LAST) begin
                state <= RUN;
                head <= '0;
                tail <= '0;
                count <= FULL;
            end
        end else begin
            head <= head + pop_n[TAG_W-1:0];
            tail <= tail + push_n[TAG_W-1:0];
            count <= count + push_n - pop_n;
        end
    end
    // Refill writes an identity pair per cycle; idx is always even here.
    always_ff @(posedge i_clock) begin
        if (!run) begin
            mem[idx_t] <= idx_t;
            mem[idx_t | ONE] <= idx_t | ONE;
        end else begin
            if (ok0) mem[tail] <= i_free_tag[0];
            if (ok1) mem[tail + TAG_W'(ok0)] <= i_free_tag[1];
        end
    end
endmodule

// File: tb/tb_rename_tag_allocator.sv
// tb_rename_tag_allocator: scoreboard bench; released tags queue up and are compared as they are allocated.
module tb_rename_tag_allocator;
`ifdef RENAME_TAG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic i_clock = 1'b0, i_reset = 1'b1, i_flush = 1'b0, i_halt = 1'b0;
    logic [1:0] i_alloc_count = 2'd0;
    logic [4:0] o_alloc_tag [2];
    logic o_alloc_valid [2];
    logic i_free_valid [2];
    logic [4:0] i_free_tag [2];
    logic [1:0] o_capacity;
    logic o_busy, o_error;
    int checks = 0, errors = 0;
    int q[$], outq[$];
    bit used [32];
    bit run_m = 1'b0, err_m = 1'b0;

    rename_tag_allocator #(.NUM_TAGS(32)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush), .i_halt(i_halt),
        .i_alloc_count(i_alloc_count), .o_alloc_tag(o_alloc_tag), .o_alloc_valid(o_alloc_valid),
        .i_free_valid(i_free_valid), .i_free_tag(i_free_tag), .o_capacity(o_capacity),
        .o_busy(o_busy), .o_error(o_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        int sz = q.size();
        check("busy", o_busy, !run_m);
        check("capacity", o_capacity, run_m ? (sz > 2 ? 2 : sz) : 0);
        check("valid0", o_alloc_valid[0], run_m && sz > 0);
        check("valid1", o_alloc_valid[1], run_m && sz > 1);
        check("error", o_error, err_m);
        if (run_m && sz > 0) check("tag0", o_alloc_tag[0], q[0]);
        if (run_m && sz > 1) check("tag1", o_alloc_tag[1], q[1]);
    endtask

    task automatic model_clear();
        q.delete();
        outq.delete();
        used = '{default: 1'b0};
        run_m = 1'b0;
    endtask

    task automatic drive(input int a, input bit v0, input int t0, input bit v1, input int t1,
                         input bit h = 1'b0, input bit f = 1'b0);
        int sz0, cap, t;
        bit ok0, ok1;
        i_alloc_count = 2'(a);
        i_free_valid[0] = v0;
        i_free_tag[0] = 5'(t0);
        i_free_valid[1] = v1;
        i_free_tag[1] = 5'(t1);
        i_halt = h;
        i_flush = f;
        if (f) begin
            model_clear();
        end else if (run_m) begin
            sz0 = q.size();
            cap = sz0 > 2 ? 2 : sz0;
            ok0 = v0 && sz0 < 32 && (!CHK || used[t0]);
            if (ok0) begin
                q.push_back(t0);
                used[t0] = 1'b0;
            end
            ok1 = v1 && (sz0 + int'(ok0)) < 32 && (!CHK || used[t1]);
            if (ok1) begin
                q.push_back(t1);
                used[t1] = 1'b0;
            end
            if (CHK && ((v0 && !ok0) || (v1 && !ok1))) err_m = 1'b1;
            if (!h && a <= cap) begin
                for (int k = 0; k < a; k++) begin
                    t = q.pop_front();
                    check("alloc_tag", o_alloc_tag[k], t);
                    used[t] = 1'b1;
                    outq.push_back(t);
                end
            end else if (!h && CHK) begin
                err_m = 1'b1;
            end
        end
        @(posedge i_clock);
        #1;
        i_alloc_count = 2'd0;
        i_free_valid[0] = 1'b0;
        i_free_valid[1] = 1'b0;
        i_halt = 1'b0;
        i_flush = 1'b0;
        check_outputs();
    endtask

    task automatic wait_refill();
        for (int i = 0; i < 16; i++) begin
            check("busy_refill", o_busy, 1);
            check("cap_refill", o_capacity, 0);
            @(posedge i_clock);
            #1;
        end
        run_m = 1'b1;
        for (int i = 0; i < 32; i++) q.push_back(i);
        check_outputs();
    endtask

    initial begin
        int a, i0, t0, t1;
        bit v0, v1;
        i_free_valid[0] = 1'b0;
        i_free_valid[1] = 1'b0;
        i_free_tag[0] = '0;
        i_free_tag[1] = '0;
        model_clear();
        repeat (2) @(posedge i_clock);
        #1;
        check_outputs();
        i_reset = 1'b0;
        wait_refill();
        // Drain in order, then an over-capacity request at count=1.
        for (int i = 0; i < 15; i++) drive(2, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 7, 1, 3);
        drive(1, 1, 9, 0, 0);
        drive(2, 1, 5, 0, 0, 1'b1);
        drive(0, 1, 10, 1, 11);
        drive(0, 1, 12, 1, 13);
        drive(0, 1, 14, 1, 15);
        drive(0, 1, 16, 0, 0);
        check("count10", q.size(), 10);
        drive(0, 1, 20, 0, 0, 1'b0, 1'b1);
        wait_refill();
        // Slot-1-only release lands at tail; drain past the wrap to see it.
        err_m = CHK ? err_m : 1'b0;
        drive(2, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        outq.delete(1);
        for (int i = 0; i < 15; i++) drive(2, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, 2);
            v0 = outq.size() > 0 && $urandom_range(0, 1) == 1;
            t0 = 0;
            if (v0) begin
                i0 = $urandom_range(0, outq.size() - 1);
                t0 = outq[i0];
                outq.delete(i0);
            end
            v1 = outq.size() > 0 && $urandom_range(0, 1) == 1;
            t1 = 0;
            if (v1) begin
                i0 = $urandom_range(0, outq.size() - 1);
                t1 = outq[i0];
                outq.delete(i0);
            end
            drive(a, v0, t0, v1, t1, $urandom_range(0, 3) == 0);
        end
        // Flush during refill restarts it.
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("busy_early", o_busy, 1);
            @(posedge i_clock);
            #1;
        end
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        wait_refill();
        // Asynchronous reset mid-run clears the sticky flag.
        drive(2, 0, 0, 0, 0);
        #2;
        i_reset = 1'b1;
        #1;
        model_clear();
        err_m = 1'b0;
        check_outputs();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        wait_refill();
`ifdef RENAME_TAG_CHECK_EN
        drive(0, 1, 4, 0, 0);
        check("double_free_flag", o_error, 1);
        check("double_free_count", q.size(), 32);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
`else
        drive(2, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1);
        check("error_off", o_error, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
